// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio stream sink.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {
    MUTED   = 1'b0,
    PLAYING = 1'b1
  } state_e;

  // Signed two's complement to unsigned offset binary: flip the sign bit.
  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/audio_stream_sink_sample_fifo.sv
// Small synchronous FIFO for PCM samples. Registered read/write pointers
// and occupancy; a push into a full FIFO is only honoured when a pop
// happens in the same cycle.
module sample_fifo
  import audio_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = SAMPLE_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers, storage and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/audio_stream_sink.sv
// Consumer of the 32-bit stb/ack audio stream: buffers PCM samples,
// plays them at a fixed sample rate through a first-order sigma-delta
// modulator and drives the amplifier shutdown pin.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   MUTED   | amplifier off, sample forced to 0, waiting for PRIME_LEVEL
//   PLAYING | amplifier on, one sample popped per tick, underruns counted
module audio_stream_sink
  import audio_pkg::*;
#(
  parameter int CLK_DIV     = 2268,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int MUTE_AFTER  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_audio,
  input  logic        input_audio_stb,
  output logic        input_audio_ack,
  output logic        audio_pwm,
  output logic        audio_sd,
  output logic [15:0] underrun_count
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RUN_W = $clog2(MUTE_AFTER + 1);

  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(CLK_DIV - 1);
  localparam logic [OCC_W-1:0] PRIME_C = OCC_W'(PRIME_LEVEL);
  localparam logic [RUN_W-1:0] MUTE_C  = RUN_W'(MUTE_AFTER);

  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                ack_q, ack_d;
  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [15:0]         underrun_q, underrun_d;
  logic                sd_q, sd_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic                pwm_q, pwm_d;
  logic [SAMPLE_W:0]   mod_sum;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [OCC_W-1:0]    fifo_count;
  logic                unused_hi;

  // Upper half of the stream word carries nothing for this sink.
  assign unused_hi = ^input_audio[31:16];

  assign tick      = (tick_cnt_q == TICK_AT);
  assign fifo_push = input_audio_stb && ack_q;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (input_audio[SAMPLE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Free-running sample-period counter, wraps on the tick.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
  end

  // A tick pops when priming completes (MUTED) or when data is available (PLAYING).
  always_comb begin
    fifo_pop = 1'b0;
    if (tick) begin
      if (state_q == MUTED) begin
        fifo_pop = (fifo_count >= PRIME_C);
      end else begin
        fifo_pop = !fifo_empty;
      end
    end
  end

  // Ack only when idle; with ack low nothing is pushed this cycle, so room
  // after the pop is "not full, or popping".
  always_comb begin
    ack_d = input_audio_stb && !ack_q && (!fifo_full || fifo_pop);
  end

  // Playback state, current sample and underrun bookkeeping.
  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    run_d      = run_q;
    underrun_d = underrun_q;
    case (state_q)
      MUTED: begin
        sample_d = '0;
        run_d    = '0;
        if (fifo_pop) begin
          state_d  = PLAYING;
          sample_d = fifo_dout;
        end
      end
      PLAYING: begin
        if (tick) begin
          if (fifo_pop) begin
            sample_d = fifo_dout;
            run_d    = '0;
          end else begin
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
            if (run_q + RUN_W'(1) == MUTE_C) begin
              state_d  = MUTED;
              sample_d = '0;
              run_d    = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
      end
      default: state_d = MUTED;
    endcase
    sd_d = (state_q == PLAYING);
  end

  // First-order sigma-delta: carry out of the 16-bit accumulator is the bit.
  always_comb begin
    mod_sum = {1'b0, acc_q} + {1'b0, to_offset_binary(sample_q)};
    acc_d   = mod_sum[SAMPLE_W-1:0];
    pwm_d   = mod_sum[SAMPLE_W];
  end

  // All block state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      ack_q      <= 1'b0;
      state_q    <= MUTED;
      sample_q   <= '0;
      run_q      <= '0;
      underrun_q <= '0;
      sd_q       <= 1'b0;
      acc_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      ack_q      <= ack_d;
      state_q    <= state_d;
      sample_q   <= sample_d;
      run_q      <= run_d;
      underrun_q <= underrun_d;
      sd_q       <= sd_d;
      acc_q      <= acc_d;
      pwm_q      <= pwm_d;
    end
  end

  assign input_audio_ack = ack_q;
  assign audio_pwm       = pwm_q;
  assign audio_sd        = sd_q;
  assign underrun_count  = underrun_q;

endmodule

// File: tb/tb_audio_stream_sink.sv
`timescale 1ns/1ps
module tb_audio_stream_sink;

  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 4;
  localparam int PRIME   = 2;
  localparam int MUTE    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_audio = '0;
  logic        stb = 1'b0;
  logic        ack, pwm, sd;
  logic [15:0] underrun;

  int          checks = 0;
  int          errors = 0;
  int          since_rst = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  always #5 clk = ~clk;

  audio_stream_sink #(
    .CLK_DIV     (CLK_DIV),
    .FIFO_DEPTH  (DEPTH),
    .PRIME_LEVEL (PRIME),
    .MUTE_AFTER  (MUTE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .input_audio     (input_audio),
    .input_audio_stb (stb),
    .input_audio_ack (ack),
    .audio_pwm       (pwm),
    .audio_sd        (sd),
    .underrun_count  (underrun)
  );

  // Edges since the last reset edge; ticks fall on multiples of CLK_DIV.
  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  // Scoreboard: every pop into the player must be the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && dut.fifo_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop unexpected pop of %h, nothing outstanding", dut.fifo_dout);
      end else begin
        sb_exp = exp_q.pop_front();
        if (dut.fifo_dout !== sb_exp) begin
          errors++;
          $display("FAIL sb_pop got %h want %h", dut.fifo_dout, sb_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    stb = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Offer one word (stb left high); ok = accepted in bound with a 1-cycle ack.
  task automatic send_word(input logic [15:0] data, output bit ok, output int xfer_edge);
    int n = 0;
    ok = 1'b0;
    xfer_edge = -1;
    input_audio = {16'($urandom), data};
    stb = 1'b1;
    while (ack !== 1'b1 && n < 4 * CLK_DIV) begin
      step();
      n++;
    end
    if (ack === 1'b1) begin
      exp_q.push_back(data);
      step();
      xfer_edge = since_rst;
      ok = (ack === 1'b0);
    end
  endtask

  task automatic wait_sd(input logic val, input int limit, output bit ok);
    int n = 0;
    while (sd !== val && n < limit) begin
      step();
      n++;
    end
    ok = (sd === val);
  endtask

  task automatic test_reset();
    logic prev;
    int toggles = 0, ones = 0;
    bit seen_ack = 0, seen_sd = 0;
    apply_reset();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd got %b want 0", sd); end
    checks++; if (underrun !== 16'd0) begin errors++; $display("FAIL reset_underrun got %0d want 0", underrun); end
    step();
    prev = pwm;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pwm !== prev) toggles++;
      if (pwm === 1'b1) ones++;
      prev = pwm;
      if (ack === 1'b1) seen_ack = 1;
      if (sd === 1'b1) seen_sd = 1;
    end
    checks++; if (toggles != 40) begin errors++; $display("FAIL idle_toggle got %0d want 40", toggles); end
    checks++; if (ones != 20) begin errors++; $display("FAIL idle_density got %0d want 20", ones); end
    checks++; if (seen_ack || seen_sd) begin errors++; $display("FAIL idle_quiet ack_seen %0d sd_seen %0d want 0 0", seen_ack, seen_sd); end
    checks++; if (underrun !== 16'd0) begin errors++; $display("FAIL idle_underrun got %0d want 0", underrun); end
  endtask

  task automatic test_play_full();
    bit ok1, ok2, ok, feed_ok;
    int e1, e2, ones;
    apply_reset();
    send_word(16'h7FFF, ok1, e1);
    send_word(16'h7FFF, ok2, e2);
    stb = 1'b0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL full_ack got %0d%0d want 11", ok1, ok2); end
    wait_sd(1'b1, 2 * CLK_DIV, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_sd_rise got %b want 1", sd); end
    checks++; if (since_rst % CLK_DIV != 1 || since_rst - e2 > CLK_DIV + 1) begin
      errors++; $display("FAIL full_sd_timing got edge %0d want first tick+1 after %0d", since_rst, e2);
    end
    checks++; if (dut.sample_q !== 16'h7FFF) begin errors++; $display("FAIL full_sample got %h want 7fff", dut.sample_q); end
    feed_ok = 1;
    ones = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send_word(16'h7FFF, ok, e1);
          if (!ok) feed_ok = 0;
        end
        stb = 1'b0;
      end
      begin
        for (int i = 0; i < 64; i++) begin
          step();
          if (pwm === 1'b1) ones++;
        end
      end
    join
    checks++; if (!feed_ok) begin errors++; $display("FAIL full_feed got 0 want 1"); end
    checks++; if (ones < 63) begin errors++; $display("FAIL full_density got %0d want >=63", ones); end
    wait_sd(1'b0, 16 * CLK_DIV, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_mute got sd %b want 0", sd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    int e, xe[6];
    apply_reset();
    send_word(16'h1111, ok, e);
    all_ok = ok;
    send_word(16'h2222, ok, e);
    all_ok &= ok;
    stb = 1'b0;
    wait_sd(1'b1, 2 * CLK_DIV, ok);
    all_ok &= ok;
    for (int i = 0; i < 6; i++) begin
      send_word(16'h3000 + 16'(i), ok, xe[i]);
      all_ok &= ok;
      if (i == 2) begin
        checks++; if (dut.fifo_count !== 3'd4 || ack !== 1'b0) begin
          errors++; $display("FAIL b2b_full got occ %0d ack %b want 4 0", dut.fifo_count, ack);
        end
      end
    end
    stb = 1'b0;
    checks++; if (!all_ok) begin errors++; $display("FAIL b2b_accept got 0 want 1"); end
    checks++; if (xe[4] % CLK_DIV != 1 || xe[5] - xe[4] != CLK_DIV) begin
      errors++; $display("FAIL b2b_pace got edges %0d %0d want tick+1 spaced %0d", xe[4], xe[5], CLK_DIV);
    end
    wait_sd(1'b0, 16 * CLK_DIV, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_mute got sd %b want 0", sd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_underrun_mute();
    bit ok, ok2;
    int e, base, ones;
    logic [15:0] u15, u16v, u24, u32;
    logic sd32;
    apply_reset();
    send_word(16'h8000, ok, e);
    send_word(16'h8000, ok2, e);
    stb = 1'b0;
    wait_sd(1'b1, 2 * CLK_DIV, ok);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL neg_start got sd %b want 1", sd); end
    base = since_rst - 1;
    ones = (pwm === 1'b1) ? 1 : 0;
    u15 = 'x; u16v = 'x; u24 = 'x;
    for (int i = 0; i < 31; i++) begin
      step();
      if (pwm === 1'b1) ones++;
      if (since_rst == base + 15) u15 = underrun;
      if (since_rst == base + 16) u16v = underrun;
      if (since_rst == base + 24) u24 = underrun;
    end
    u32 = underrun;
    sd32 = sd;
    checks++; if (ones != 0) begin errors++; $display("FAIL neg_density got %0d want 0", ones); end
    checks++; if (u15 !== 16'd0 || u16v !== 16'd1 || u24 !== 16'd2 || u32 !== 16'd3) begin
      errors++; $display("FAIL neg_underrun got %0d %0d %0d %0d want 0 1 2 3", u15, u16v, u24, u32);
    end
    checks++; if (sd32 !== 1'b1) begin errors++; $display("FAIL neg_sd_hold got %b want 1", sd32); end
    step();
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL neg_sd_off got %b want 0", sd); end
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm === 1'b1) ones++;
    end
    checks++; if (ones != 8) begin errors++; $display("FAIL neg_silence got %0d want 8", ones); end
    checks++; if (underrun !== 16'd3 || exp_q.size() != 0) begin
      errors++; $display("FAIL neg_final got underrun %0d left %0d want 3 0", underrun, exp_q.size());
    end
  endtask

  task automatic test_reset_midxfer();
    bit ok, all_ok;
    int e, n;
    apply_reset();
    send_word(16'h4001, ok, e); all_ok = ok;
    send_word(16'h4002, ok, e); all_ok &= ok;
    send_word(16'h4003, ok, e); all_ok &= ok;
    input_audio = {16'hABCD, 16'h4004};
    n = 0;
    while (ack !== 1'b1 && n < 4 * CLK_DIV) begin
      step();
      n++;
    end
    checks++; if (!all_ok || ack !== 1'b1 || dut.fifo_count !== 3'd3) begin
      errors++; $display("FAIL rst_setup got ok %0d ack %b occ %0d want 1 1 3", all_ok, ack, dut.fifo_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    checks++; if (ack !== 1'b0 || dut.fifo_count !== 3'd0 || sd !== 1'b0 || underrun !== 16'd0) begin
      errors++; $display("FAIL rst_mid got ack %b occ %0d sd %b und %0d want 0 0 0 0", ack, dut.fifo_count, sd, underrun);
    end
    send_word(16'h4004, ok, e); all_ok = ok;
    send_word(16'h4005, ok, e); all_ok &= ok;
    stb = 1'b0;
    wait_sd(1'b1, 2 * CLK_DIV, ok); all_ok &= ok;
    wait_sd(1'b0, 8 * CLK_DIV, ok); all_ok &= ok;
    checks++; if (!all_ok || exp_q.size() != 0) begin
      errors++; $display("FAIL rst_reoffer got ok %0d left %0d want 1 0", all_ok, exp_q.size());
    end
  endtask

  task automatic test_push_pop_same();
    bit ok, all_ok;
    int e, n;
    apply_reset();
    send_word(16'h5001, ok, e); all_ok = ok;
    send_word(16'h5002, ok, e); all_ok &= ok;
    send_word(16'h5003, ok, e); all_ok &= ok;
    stb = 1'b0;
    wait_sd(1'b1, 2 * CLK_DIV, ok); all_ok &= ok;
    n = 0;
    while (since_rst % CLK_DIV != CLK_DIV - 2 && n < 2 * CLK_DIV) begin
      step();
      n++;
    end
    input_audio = {16'h0000, 16'h5004};
    stb = 1'b1;
    step();
    checks++; if (!all_ok || ack !== 1'b1 || dut.fifo_count !== 3'd2 || dut.fifo_dout !== 16'h5002) begin
      errors++; $display("FAIL pp_before got ok %0d ack %b occ %0d head %h want 1 1 2 5002", all_ok, ack, dut.fifo_count, dut.fifo_dout);
    end
    exp_q.push_back(16'h5004);
    step();
    stb = 1'b0;
    checks++; if (dut.fifo_count !== 3'd2 || dut.sample_q !== 16'h5002 || ack !== 1'b0) begin
      errors++; $display("FAIL pp_after got occ %0d sample %h ack %b want 2 5002 0", dut.fifo_count, dut.sample_q, ack);
    end
    wait_sd(1'b0, 10 * CLK_DIV, ok);
    checks++; if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL pp_drain got sd %b left %0d want 0 0", sd, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_play_full();
    test_back_to_back();
    test_underrun_mute();
    test_reset_midxfer();
    test_push_pop_same();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
